// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// column drive patterns, scan result record and the key map.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT,
        ST_EVAL
    } scan_state_t;

    localparam logic [3:0] COL_C1   = 4'b0111;
    localparam logic [3:0] COL_C2   = 4'b1011;
    localparam logic [3:0] COL_C3   = 4'b1101;
    localparam logic [3:0] COL_C4   = 4'b1110;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // "none" is always encoded with code 0 so results compare by value
    typedef struct packed {
        logic       is_key;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t RES_NONE = '0;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    col_drive = COL_C1;
            2'd1:    col_drive = COL_C2;
            2'd2:    col_drive = COL_C3;
            default: col_drive = COL_C4;
        endcase
    endfunction

    // Index is {column, row} with column 0 = C1 and row 0 = R1
    function automatic logic [3:0] key_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    key_lookup = 4'h1;
            4'd1:    key_lookup = 4'h4;
            4'd2:    key_lookup = 4'h7;
            4'd3:    key_lookup = 4'h0;
            4'd4:    key_lookup = 4'h2;
            4'd5:    key_lookup = 4'h5;
            4'd6:    key_lookup = 4'h8;
            4'd7:    key_lookup = 4'hF;
            4'd8:    key_lookup = 4'h3;
            4'd9:    key_lookup = 4'h6;
            4'd10:   key_lookup = 4'h9;
            4'd11:   key_lookup = 4'hE;
            4'd12:   key_lookup = 4'hA;
            4'd13:   key_lookup = 4'hB;
            4'd14:   key_lookup = 4'hC;
            default: key_lookup = 4'hD;
        endcase
    endfunction

    function automatic logic [2:0] count_ones(input logic [3:0] v);
        count_ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: a result must repeat DEBOUNCE_SCANS times before it
// becomes the debounced state; new key states raise a same-cycle event.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_valid,
    input  scan_res_t  scan_res,
    output logic       deb_key,
    output logic       evt,
    output logic [3:0] evt_code
);

    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);

    scan_res_t        prev_reg;
    scan_res_t        deb_reg;
    logic [STB_W-1:0] stable_reg;
    logic [STB_W-1:0] stable_next;
    logic             accept;

    always_comb begin
        stable_next = STB_W'(1);
        if (scan_res == prev_reg) begin
            stable_next = (stable_reg == STB_MAX) ? stable_reg : stable_reg + STB_W'(1);
        end
        // Accept only on a genuine change so a saturated counter never re-fires
        accept   = scan_valid && (stable_next == STB_MAX) && (scan_res != deb_reg);
        evt      = accept && scan_res.is_key;
        evt_code = scan_res.code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg   <= RES_NONE;
            deb_reg    <= RES_NONE;
            stable_reg <= '0;
        end else if (scan_valid) begin
            prev_reg   <= scan_res;
            stable_reg <= stable_next;
            if (accept) begin
                deb_reg <= scan_res;
            end
        end
    end

    assign deb_key = deb_reg.is_key;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one-cold columns, samples rows after a
// settle delay, debounces whole scans and hands key events over valid/ready.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int COL_CYCLES     = 100000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam int CNT_W = $clog2(COL_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(COL_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t      state_reg, state_next;
    logic [CNT_W-1:0] slot_cnt_reg;
    logic [1:0]       col_idx_reg;
    logic [3:0]       col_reg;
    logic [1:0]       hits_reg, hits_next;
    logic [3:0]       code_reg;
    logic [3:0]       rows_low;
    logic [2:0]       low_cnt;
    logic [2:0]       hit_sum;
    logic [1:0]       row_idx;
    logic             slot_end;
    scan_res_t        scan_res;
    logic             evt;
    logic [3:0]       evt_code;
    logic [3:0]       key_code_reg;
    logic             key_valid_reg;
    logic             overflow_reg;

    // Row bit 3 is R1, so reverse into row-index order
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign rows_low[gi] = ~Row[3-gi];
        end
    endgenerate

    always_comb begin
        slot_end   = (slot_cnt_reg == SLOT_LAST);
        state_next = state_reg;
        case (state_reg)
            ST_DRIVE:  state_next = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (slot_cnt_reg == SETTLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_WAIT;
            ST_WAIT:   if (slot_end) state_next = (col_idx_reg == 2'd3) ? ST_EVAL : ST_DRIVE;
            ST_EVAL:   state_next = ST_DRIVE;
            default:   state_next = ST_DRIVE;
        endcase
    end

    always_comb begin
        low_cnt = count_ones(rows_low);
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (rows_low[r]) row_idx = 2'(r);
        end
        // Hit count saturates at 2: anything beyond one key is "none"
        hit_sum   = {1'b0, hits_reg} + low_cnt;
        hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_res.is_key = (hits_reg == 2'd1);
        scan_res.code   = (hits_reg == 2'd1) ? code_reg : 4'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_DRIVE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg <= '0;
            col_idx_reg  <= 2'd0;
            col_reg      <= COL_IDLE;
            hits_reg     <= 2'd0;
            code_reg     <= 4'h0;
        end else begin
            if ((state_reg == ST_WAIT && slot_end) || state_reg == ST_EVAL) begin
                slot_cnt_reg <= '0;
            end else begin
                slot_cnt_reg <= slot_cnt_reg + CNT_W'(1);
            end
            if (state_reg == ST_WAIT && slot_end) begin
                col_idx_reg <= col_idx_reg + 2'd1;
            end
            if (state_reg == ST_DRIVE) begin
                col_reg <= col_drive(col_idx_reg);
            end
            if (state_reg == ST_SAMPLE) begin
                hits_reg <= hits_next;
                if (low_cnt == 3'd1) begin
                    code_reg <= key_lookup({col_idx_reg, row_idx});
                end
            end else if (state_reg == ST_EVAL) begin
                hits_reg <= 2'd0;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_valid (state_reg == ST_EVAL),
        .scan_res   (scan_res),
        .deb_key    (key_held),
        .evt        (evt),
        .evt_code   (evt_code)
    );

    // An event arriving while the consumer still holds the last one is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            overflow_reg <= 1'b0;
            if (evt) begin
                if (!key_valid_reg || key_ready) begin
                    key_code_reg  <= evt_code;
                    key_valid_reg <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (key_valid_reg && key_ready) begin
                key_valid_reg <= 1'b0;
            end
        end
    end

    assign Col       = col_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign overflow  = overflow_reg;

endmodule
